// File: rtl/vstore_line_collector.sv
// Collects masked store beats into one VLEN-bit line and emits it as a single
// write pulse to a sink that cannot stall.
module vstore_line_collector #(
  parameter int unsigned VLEN = 1024,
  parameter int unsigned DW   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_paddr,
  input  logic [DW-1:0]     in_data,
  input  logic [DW/8-1:0]   in_mask,
  input  logic              in_last,
  output logic              out_enable,
  output logic [63:0]       out_paddr,
  output logic [VLEN-1:0]   out_store_data,
  output logic              out_partial,
  output logic [31:0]       out_line_count
);

  localparam int unsigned LINE_BYTES = VLEN / 8;
  localparam int unsigned BEAT_BYTES = DW / 8;
  localparam int unsigned OFF_W      = $clog2(LINE_BYTES);
  localparam int unsigned BOFF_W     = $clog2(BEAT_BYTES);
  localparam int unsigned SLOT_W     = OFF_W - BOFF_W;
  localparam int unsigned BASE_W     = 64 - OFF_W;

  typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;

  state_t                  state;
  logic [BASE_W-1:0]       base_q;
  logic [VLEN-1:0]         buf_q;
  logic [LINE_BYTES-1:0]   cov_q;

  logic [BASE_W-1:0]       line_addr;
  logic [SLOT_W-1:0]       slot;
  logic                    accept;
  logic                    close_line;
  logic [VLEN-1:0]         merge_buf;
  logic [LINE_BYTES-1:0]   merge_cov;
  logic [BEAT_BYTES-1:0]   mask_sh;
  logic [DW-1:0]           data_sh;
  logic [OFF_W-1:0]        byte_idx;

  assign line_addr = in_paddr[63:OFF_W];
  assign slot      = in_paddr[OFF_W-1:BOFF_W];

  // A beat for a different line is refused while a line is open.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      FILL:    in_ready = (line_addr == base_q);
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;

  // Byte-wise merge of the offered beat into the current buffer image.
  always_comb begin
    merge_buf = buf_q;
    merge_cov = cov_q;
    mask_sh   = in_mask;
    data_sh   = in_data;
    byte_idx  = OFF_W'(slot) * OFF_W'(BEAT_BYTES);
    for (int b = 0; b < int'(BEAT_BYTES); b++) begin
      if (mask_sh[0]) begin
        merge_buf[{byte_idx, 3'b000} +: 8] = data_sh[7:0];
        merge_cov[byte_idx]                = 1'b1;
      end
      mask_sh  = mask_sh >> 1;
      data_sh  = data_sh >> 8;
      byte_idx = byte_idx + 1'b1;
    end
  end

  assign close_line = (&merge_cov) || in_last;

  assign out_paddr      = {base_q, {OFF_W{1'b0}}};
  assign out_store_data = buf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      base_q         <= '0;
      buf_q          <= '0;
      cov_q          <= '0;
      out_enable     <= 1'b0;
      out_partial    <= 1'b0;
      out_line_count <= '0;
    end else begin
      out_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            base_q <= line_addr;
            buf_q  <= merge_buf;
            cov_q  <= merge_cov;
            if (close_line) begin
              state       <= EMIT;
              out_enable  <= 1'b1;
              out_partial <= ~(&merge_cov);
            end else begin
              state <= FILL;
            end
          end
        end
        FILL: begin
          if (accept) begin
            buf_q <= merge_buf;
            cov_q <= merge_cov;
            if (close_line) begin
              state       <= EMIT;
              out_enable  <= 1'b1;
              out_partial <= ~(&merge_cov);
            end
          end else if (in_valid) begin
            // Foreign-line beat flushes the open line; the beat is retried later.
            state       <= EMIT;
            out_enable  <= 1'b1;
            out_partial <= ~(&cov_q);
          end
        end
        EMIT: begin
          state          <= IDLE;
          buf_q          <= '0;
          cov_q          <= '0;
          out_line_count <= out_line_count + 32'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
